// File: rtl/cnn_stream_rx_pkg.sv
// rtl/cnn_stream_rx_pkg.sv - shared defaults, state encoding and error-flag order for the CNN stream receiver
package cnn_stream_rx_pkg;

  // Default widths: row/col/geometry and pixel data
  localparam int W_SIZE_DEF = 12;
  localparam int W_DATA_DEF = 8;

  // Receiver states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_VSYNC  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // Error flag vector bit order: {frame, long, short}
  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_FRAME = 2;
  localparam int N_ERR     = 3;

  // Saturating 16-bit increment for the statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cnn_rx_pos_cnt.sv
// rtl/cnn_rx_pos_cnt.sv - row/col position counters with end-of-line, last-pixel and line-length checks
module cnn_rx_pos_cnt #(
  parameter int W_SIZE = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              beat,
  input  logic              line_end,
  input  logic [W_SIZE-1:0] width,
  input  logic [W_SIZE-1:0] height,
  output logic [W_SIZE-1:0] row,
  output logic [W_SIZE-1:0] col,
  output logic              accept,
  output logic              eol,
  output logic              last,
  output logic              long_err,
  output logic              short_err
);

  localparam logic [W_SIZE-1:0] ONE = W_SIZE'(1);

  // col runs up to width so an overlong line is detectable before the line ends
  assign accept    = beat && (col < width);
  assign eol       = (col == width - ONE);
  assign last      = eol && (row == height - ONE);
  assign long_err  = beat && (col == width);
  assign short_err = line_end && (col != '0) && (col < width);

  // Position update: clear outside the active frame, wrap at frame end, advance row at line end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (accept && last) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      col <= col + ONE;
    end else if (line_end && (col != '0)) begin
      col <= '0;
      // a short last line pushes row to height and holds it there, so the frame never completes
      if (row != height) begin
        row <= row + ONE;
      end
    end
  end

endmodule

// File: rtl/cnn_stream_rx.sv
// rtl/cnn_stream_rx.sv - CNN frame-timing receiver: position recovery, re-timing, geometry checks; stats under CNN_RX_STATS_EN
module cnn_stream_rx
  import cnn_stream_rx_pkg::*;
#(
  parameter int W_SIZE = W_SIZE_DEF,
  parameter int W_DATA = W_DATA_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [W_SIZE-1:0] q_width,
  input  logic [W_SIZE-1:0] q_height,
  input  logic              q_start,
  input  logic              i_vsync_run,
  input  logic              i_hsync_run,
  input  logic              i_data_run,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_valid,
  output logic [W_DATA-1:0] o_data,
  output logic [W_SIZE-1:0] o_row,
  output logic [W_SIZE-1:0] o_col,
  output logic              o_eol,
  output logic              o_frame_done,
  output logic              o_err_short_line,
  output logic              o_err_long_line,
  output logic              o_err_frame,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_err_cnt
);

  state_t            state;
  logic [W_SIZE-1:0] width_q;
  logic [W_SIZE-1:0] height_q;
  logic              run_q;
  logic              last_pend;
  logic [N_ERR-1:0]  err_q;
  logic [N_ERR-1:0]  err_set;
  logic [N_ERR-1:0]  err_base;
  logic [N_ERR-1:0]  err_next;

  logic              active_beat;
  logic              beat;
  logic              line_end;
  logic              clr;
  logic              start_ok;
  logic              zero_geom;

  logic [W_SIZE-1:0] row;
  logic [W_SIZE-1:0] col;
  logic              accept;
  logic              eol;
  logic              last;
  logic              long_err;
  logic              short_err;

  // Horizontal blank carries no timing meaning here; line ends come from data_run falling
  logic              hsync_unused;
  assign hsync_unused = i_hsync_run;

  // vsync has priority over a coincident data beat
  assign active_beat = (state == ST_ACTIVE) && !i_vsync_run;
  assign beat        = active_beat && i_data_run;
  assign line_end    = active_beat && !i_data_run && run_q;
  assign clr         = (state != ST_ACTIVE) || i_vsync_run;
  assign start_ok    = (state == ST_IDLE) && q_start;
  assign zero_geom   = (q_width == '0) || (q_height == '0);

  cnn_rx_pos_cnt #(.W_SIZE(W_SIZE)) u_pos_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .beat      (beat),
    .line_end  (line_end),
    .width     (width_q),
    .height    (height_q),
    .row       (row),
    .col       (col),
    .accept    (accept),
    .eol       (eol),
    .last      (last),
    .long_err  (long_err),
    .short_err (short_err)
  );

  // Error events this cycle; a new arm clears the sticky flags before new events land
  always_comb begin
    err_set            = '0;
    err_set[ERR_SHORT] = short_err;
    err_set[ERR_LONG]  = long_err;
    err_set[ERR_FRAME] = (start_ok && zero_geom) || ((state == ST_ACTIVE) && i_vsync_run);
    err_base           = start_ok ? '0 : err_q;
    err_next           = err_base | err_set;
  end

  assign o_err_short_line = err_q[ERR_SHORT];
  assign o_err_long_line  = err_q[ERR_LONG];
  assign o_err_frame      = err_q[ERR_FRAME];
  assign o_busy           = (state != ST_IDLE);

  // Receiver FSM, sticky errors and one-cycle re-timing of accepted pixels
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      run_q        <= 1'b0;
      last_pend    <= 1'b0;
      err_q        <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_row        <= '0;
      o_col        <= '0;
      o_eol        <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      run_q        <= i_data_run;
      err_q        <= err_next;
      o_valid      <= accept;
      o_eol        <= accept && eol;
      last_pend    <= accept && last;
      o_frame_done <= last_pend;
      if (accept) begin
        o_data <= i_data;
        o_row  <= row;
        o_col  <= col;
      end
      case (state)
        ST_IDLE: begin
          if (q_start) begin
            width_q  <= q_width;
            height_q <= q_height;
            if (!zero_geom) begin
              state <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (i_vsync_run) begin
            state <= ST_VSYNC;
          end
        end
        ST_VSYNC: begin
          if (!i_vsync_run) begin
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (i_vsync_run) begin
            state <= ST_VSYNC;
          end else if (accept && last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CNN_RX_STATS_EN
  logic        err_new;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  assign err_new = |(err_set & ~err_base);

  // Saturating frame and error-event counters, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (last_pend) begin
        frame_cnt <= sat_inc16(frame_cnt);
      end
      if (err_new) begin
        err_cnt <= sat_inc16(err_cnt);
      end
    end
  end

  assign o_frame_cnt = frame_cnt;
  assign o_err_cnt   = err_cnt;
`else
  assign o_frame_cnt = '0;
  assign o_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_cnn_stream_rx.sv
// tb/tb_cnn_stream_rx.sv - self-checking bench for cnn_stream_rx against a frame-level reference model
module tb_cnn_stream_rx;

  localparam int WS = 12;
  localparam int WD = 8;
  localparam int PW = 2 * WS + WD + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [WS-1:0] q_width = '0;
  logic [WS-1:0] q_height = '0;
  logic          q_start = 1'b0;
  logic          i_vsync_run = 1'b0;
  logic          i_hsync_run = 1'b0;
  logic          i_data_run = 1'b0;
  logic [WD-1:0] i_data = '0;
  logic          o_valid;
  logic [WD-1:0] o_data;
  logic [WS-1:0] o_row;
  logic [WS-1:0] o_col;
  logic          o_eol;
  logic          o_frame_done;
  logic          o_err_short_line;
  logic          o_err_long_line;
  logic          o_err_frame;
  logic          o_busy;
  logic [15:0]   o_frame_cnt;
  logic [15:0]   o_err_cnt;

  cnn_stream_rx dut (
    .clk              (clk),
    .rstn             (rstn),
    .q_width          (q_width),
    .q_height         (q_height),
    .q_start          (q_start),
    .i_vsync_run      (i_vsync_run),
    .i_hsync_run      (i_hsync_run),
    .i_data_run       (i_data_run),
    .i_data           (i_data),
    .o_valid          (o_valid),
    .o_data           (o_data),
    .o_row            (o_row),
    .o_col            (o_col),
    .o_eol            (o_eol),
    .o_frame_done     (o_frame_done),
    .o_err_short_line (o_err_short_line),
    .o_err_long_line  (o_err_long_line),
    .o_err_frame      (o_err_frame),
    .o_busy           (o_busy),
    .o_frame_cnt      (o_frame_cnt),
    .o_err_cnt        (o_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  logic [PW-1:0] obs_q[$];
  int last_valid_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (o_valid) begin
      obs_q.push_back({o_row, o_col, o_data, o_eol});
      last_valid_cyc = cyc;
    end
    if (o_frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Stimulus description and reference-model state
  int            line_len[$];
  logic [WD-1:0] beat_data[$];
  bit            e_short = 0;
  bit            e_long = 0;
  bit            e_frame = 0;
  bit            rx_active = 0;
  int            exp_frames = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int w, input int h);
    q_width  = WS'(w);
    q_height = WS'(h);
    q_start  = 1'b1;
    step();
    q_start  = 1'b0;
    e_short  = 0;
    e_long   = 0;
    e_frame  = (w == 0) || (h == 0);
    chk("busy_after_start", o_busy, !e_frame);
  endtask

  task automatic drive_frame(input int nv, input int nh);
    beat_data.delete();
    i_vsync_run = 1'b1;
    repeat (nv) step();
    i_vsync_run = 1'b0;
    foreach (line_len[li]) begin
      i_hsync_run = 1'b1;
      i_data_run  = 1'b0;
      repeat (nh) step();
      i_hsync_run = 1'b0;
      for (int k = 0; k < line_len[li]; k++) begin
        i_data_run = 1'b1;
        i_data     = WD'($urandom);
        beat_data.push_back(i_data);
        step();
      end
    end
    i_data_run  = 1'b0;
    i_hsync_run = 1'b1;
    repeat (3) step();
    i_hsync_run = 1'b0;
  endtask

  // Drive one frame of line_len and compare against the frame-level model
  task automatic run_frame(input int w, input int h, input int nv, input int nh);
    logic [PW-1:0] exp_q[$];
    int row;
    int bi;
    int done0;
    bit done;
    if (rx_active) e_frame = 1;
    else start(w, h);
    obs_q.delete();
    done0 = done_cnt;
    drive_frame(nv, nh);
    row = 0;
    bi = 0;
    done = 0;
    foreach (line_len[li]) begin
      for (int k = 0; k < line_len[li]; k++) begin
        logic [WD-1:0] d;
        d = beat_data[bi];
        bi++;
        if (!done) begin
          if (k < w) begin
            exp_q.push_back({row[WS-1:0], k[WS-1:0], d, (k == w - 1)});
            if (row == h - 1 && k == w - 1) done = 1;
          end else begin
            e_long = 1;
          end
        end
      end
      if (!done) begin
        if (line_len[li] < w) e_short = 1;
        if (row < h) row++;
      end
    end
    chk("pixel_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("pixel_%0d", i), obs_q[i], exp_q[i]);
    end
    chk("frame_done_count", done_cnt - done0, done);
    if (done) begin
      chk("frame_done_timing", done_cyc, last_valid_cyc + 1);
      exp_frames++;
    end
    rx_active = !done;
    chk("err_short", o_err_short_line, e_short);
    chk("err_long", o_err_long_line, e_long);
    chk("err_frame", o_err_frame, e_frame);
    chk("busy", o_busy, rx_active);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data_pos"}, {o_data, o_row, o_col}, 0);
    chk({tag, "_flags"}, {o_eol, o_frame_done, o_err_short_line, o_err_long_line, o_err_frame, o_busy}, 0);
    chk({tag, "_counters"}, {o_frame_cnt, o_err_cnt}, 0);
  endtask

  initial begin
    int w;
    int h;
    int exp_err_cnt;

    // Reset state
    repeat (3) step();
    check_reset_outputs("reset");
    rstn = 1'b1;
    step();

    // Zero geometry: frame error, receiver stays idle
    start(0, 3);
    step();
    chk("zero_geom_err_frame", o_err_frame, 1);
    chk("zero_geom_idle", o_busy, 0);

    // Basic 4x2 frame with fixed blanking
    line_len = '{4, 4};
    run_frame(4, 2, 3, 2);

    // Random clean frames
    for (int n = 0; n < 3; n++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      line_len.delete();
      for (int l = 0; l < h; l++) line_len.push_back(w);
      run_frame(w, h, $urandom_range(1, 3), $urandom_range(1, 3));
    end

    // Short first line
    line_len = '{3, 4};
    run_frame(4, 2, 2, 2);

    // Long first line
    line_len = '{5, 4};
    run_frame(4, 2, 2, 1);

    // vsync after one of two lines, then a full frame
    line_len = '{4};
    run_frame(4, 2, 2, 2);
    line_len = '{4, 4};
    run_frame(4, 2, 2, 2);

    // Reset in the middle of line 1
    start(4, 2);
    i_vsync_run = 1'b1;
    repeat (2) step();
    i_vsync_run = 1'b0;
    step();
    i_data_run = 1'b1;
    repeat (4) begin i_data = WD'($urandom); step(); end
    i_data_run = 1'b0;
    step();
    i_data_run = 1'b1;
    repeat (2) begin i_data = WD'($urandom); step(); end
    rstn = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    i_data_run = 1'b0;
    step();
    rstn = 1'b1;
    step();
    rx_active = 0;
    line_len = '{4, 4};
    run_frame(4, 2, 2, 2);

    // Statistics: 3 clean frames then a frame whose last line is short
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    rx_active  = 0;
    exp_frames = 0;
    line_len = '{3, 3};
    for (int n = 0; n < 3; n++) run_frame(3, 2, 2, 2);
    line_len = '{3, 2};
    run_frame(3, 2, 2, 2);
`ifdef CNN_RX_STATS_EN
    exp_err_cnt = 1;
    chk("frame_cnt", o_frame_cnt, exp_frames);
`else
    exp_err_cnt = 0;
    chk("frame_cnt", o_frame_cnt, 0);
`endif
    chk("err_cnt", o_err_cnt, exp_err_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
